// File: rtl/product_acc_pkg.sv
// Shared constants for the product accumulator: FSM state encoding,
// default widths/length and the accumulator-width sanity helper.
package product_acc_pkg;

    typedef logic [0:0] state_t;

    localparam state_t ACCUM = 1'b0;
    localparam state_t HOLD  = 1'b1;

    localparam int DEF_PROD_W = 60;
    localparam int DEF_ACC_W  = 68;
    localparam int DEF_LEN    = 16;

    function automatic bit acc_w_ok(input int acc_w, input int prod_w);
        return acc_w >= prod_w;
    endfunction

endpackage

// File: rtl/product_accumulator_if.sv
// Product input / frame-sum output bundle between the multiplier, the
// accumulator (slave) and its consumer (master side drives inputs, takes results).
interface product_accumulator_if
    import product_acc_pkg::*;
#(
    parameter int PROD_W = DEF_PROD_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int LEN    = DEF_LEN
);
    localparam int CNT_W = $clog2(LEN + 1);

    // A transfer happens on a rising edge where valid && ready; the sender keeps
    // valid and payload stable until then, ready may change freely.
    logic              in_valid;
    logic              in_ready;
    logic [PROD_W-1:0] in_product;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_sum;
    logic [CNT_W-1:0]  out_count;
    logic              out_ovf;

    modport master (
        output in_valid, in_product, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_count, out_ovf
    );

    modport slave (
        input  in_valid, in_product, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_count, out_ovf
    );

endinterface

// File: rtl/product_accumulator_sat_adder.sv
// W-bit unsigned adder with carry out; with SATURATE_EN defined the sum
// clamps to all-ones whenever the add carries, otherwise it wraps.
module sat_adder #(
    parameter int W = 68
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         carry
);
    logic [W-1:0] raw;

    assign {carry, raw} = {1'b0, a} + {1'b0, b};

`ifdef SATURATE_EN
    assign sum = carry ? {W{1'b1}} : raw;
`else
    assign sum = raw;
`endif

endmodule

// File: rtl/product_accumulator.sv
// Sums up to LEN multiplier products per frame and presents the total on a
// valid/ready result port. Build option: SATURATE_EN (clamp instead of wrap).
module product_accumulator
    import product_acc_pkg::*;
#(
    parameter int PROD_W = DEF_PROD_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int LEN    = DEF_LEN
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    product_accumulator_if.slave     bus,
    output state_t                   dbg_state
);
    localparam int CNT_W = $clog2(LEN + 1);

    state_t            state;
    logic [ACC_W-1:0]  acc;
    logic [CNT_W-1:0]  cnt;
    logic              ovf;
    logic [ACC_W-1:0]  sum_q;
    logic [CNT_W-1:0]  count_q;
    logic              ovf_q;
    logic              valid_q;

    logic [ACC_W-1:0]  prod_ext;
    logic [ACC_W-1:0]  add_sum;
    logic              add_carry;
    logic              in_ready;
    logic              frame_end;

    assign prod_ext  = ACC_W'(bus.in_product);
    assign in_ready  = (state == ACCUM);
    assign frame_end = bus.in_last || (cnt == CNT_W'(LEN - 1));

    sat_adder #(.W(ACC_W)) u_add (
        .a     (acc),
        .b     (prod_ext),
        .sum   (add_sum),
        .carry (add_carry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ACCUM;
            acc     <= '0;
            cnt     <= '0;
            ovf     <= 1'b0;
            sum_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else if (clear) begin
            // Abort wipes the partial frame and any unconsumed result flag, but
            // the last result payload stays visible.
            state   <= ACCUM;
            acc     <= '0;
            cnt     <= '0;
            ovf     <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (bus.in_valid) begin
                        if (frame_end) begin
                            sum_q   <= add_sum;
                            count_q <= cnt + CNT_W'(1);
                            ovf_q   <= ovf | add_carry;
                            valid_q <= 1'b1;
                            acc     <= '0;
                            cnt     <= '0;
                            ovf     <= 1'b0;
                            state   <= HOLD;
                        end else begin
                            acc <= add_sum;
                            cnt <= cnt + CNT_W'(1);
                            ovf <= ovf | add_carry;
                        end
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        valid_q <= 1'b0;
                        state   <= ACCUM;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = valid_q;
    assign bus.out_sum   = sum_q;
    assign bus.out_count = count_q;
    assign bus.out_ovf   = ovf_q;
    assign dbg_state     = state;

    a_acc_w_ok: assert property (@(posedge clk) acc_w_ok(ACC_W, PROD_W));

    a_product_stable: assert property (@(posedge clk) disable iff (!rst_n || clear)
        (bus.in_valid && !in_ready) |=> (!bus.in_valid || $stable(bus.in_product)));

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator: a 10-bit-accumulator instance for
// the main scenarios and an 8-bit-accumulator instance for overflow behaviour.
module tb_product_accumulator;
    import product_acc_pkg::*;

    logic   clk;
    logic   rst_n;
    logic   clear_a;
    logic   clear_b;
    state_t dbg_a;
    state_t dbg_b;

    int checks = 0;
    int errors = 0;

    product_accumulator_if #(.PROD_W(8), .ACC_W(10), .LEN(4)) a_if ();
    product_accumulator_if #(.PROD_W(8), .ACC_W(8),  .LEN(4)) b_if ();

    product_accumulator #(.PROD_W(8), .ACC_W(10), .LEN(4)) dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear_a),
        .bus       (a_if),
        .dbg_state (dbg_a)
    );

    product_accumulator #(.PROD_W(8), .ACC_W(8), .LEN(4)) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear_b),
        .bus       (b_if),
        .dbg_state (dbg_b)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- drivers ----------------
    task automatic drive_a(input logic v, input logic [7:0] p, input logic l);
        a_if.in_valid   = v;
        a_if.in_product = p;
        a_if.in_last    = l;
    endtask

    task automatic drive_b(input logic v, input logic [7:0] p, input logic l);
        b_if.in_valid   = v;
        b_if.in_product = p;
        b_if.in_last    = l;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({a_if.out_valid, a_if.out_sum, a_if.out_count, a_if.out_ovf} !== 15'd0) begin
            errors++;
            $display("FAIL reset_a_outputs got %h exp %h",
                     {a_if.out_valid, a_if.out_sum, a_if.out_count, a_if.out_ovf}, 15'd0);
        end
        rst_n = 1'b1;
        step();
        checks++;
        if ({a_if.in_ready, dbg_a, b_if.in_ready, b_if.out_valid, b_if.out_sum} !== {1'b1, ACCUM, 1'b1, 1'b0, 8'd0}) begin
            errors++;
            $display("FAIL reset_release got %b exp %b",
                     {a_if.in_ready, dbg_a, b_if.in_ready, b_if.out_valid, b_if.out_sum},
                     {1'b1, ACCUM, 1'b1, 1'b0, 8'd0});
        end
    endtask

    task automatic test_back_to_back();
        a_if.out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            drive_a(1'b1, 8'(i), 1'b0);
            step();
        end
        drive_a(1'b0, 8'd0, 1'b0);
        checks++;
        if ({a_if.out_valid, a_if.out_sum, a_if.out_count, a_if.out_ovf, a_if.in_ready} !== {1'b1, 10'd10, 3'd4, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL b2b_result got v=%b sum=%0d cnt=%0d ovf=%b rdy=%b exp v=1 sum=10 cnt=4 ovf=0 rdy=0",
                     a_if.out_valid, a_if.out_sum, a_if.out_count, a_if.out_ovf, a_if.in_ready);
        end
        step();
        checks++;
        if ({a_if.out_valid, a_if.in_ready, a_if.out_sum} !== {1'b0, 1'b1, 10'd10}) begin
            errors++;
            $display("FAIL b2b_after got v=%b rdy=%b sum=%0d exp v=0 rdy=1 sum=10",
                     a_if.out_valid, a_if.in_ready, a_if.out_sum);
        end
    endtask

    task automatic test_in_last();
        drive_a(1'b1, 8'd5, 1'b0);
        step();
        drive_a(1'b1, 8'd7, 1'b1);
        step();
        drive_a(1'b0, 8'd0, 1'b0);
        checks++;
        if ({a_if.out_valid, a_if.out_sum, a_if.out_count, a_if.out_ovf} !== {1'b1, 10'd12, 3'd2, 1'b0}) begin
            errors++;
            $display("FAIL last_early got v=%b sum=%0d cnt=%0d ovf=%b exp v=1 sum=12 cnt=2 ovf=0",
                     a_if.out_valid, a_if.out_sum, a_if.out_count, a_if.out_ovf);
        end
        step();
        for (int i = 0; i < 4; i++) begin
            drive_a(1'b1, 8'd1, 1'b0);
            step();
        end
        drive_a(1'b0, 8'd0, 1'b0);
        checks++;
        if ({a_if.out_valid, a_if.out_sum, a_if.out_count} !== {1'b1, 10'd4, 3'd4}) begin
            errors++;
            $display("FAIL last_next_frame got v=%b sum=%0d cnt=%0d exp v=1 sum=4 cnt=4",
                     a_if.out_valid, a_if.out_sum, a_if.out_count);
        end
        step();
    endtask

    task automatic test_backpressure();
        a_if.out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            drive_a(1'b1, 8'(i), 1'b0);
            step();
        end
        drive_a(1'b1, 8'd9, 1'b0);
        for (int c = 0; c < 4; c++) begin
            checks++;
            if ({a_if.out_valid, a_if.out_sum, a_if.in_ready, dbg_a} !== {1'b1, 10'd10, 1'b0, HOLD}) begin
                errors++;
                $display("FAIL bp_hold_c%0d got v=%b sum=%0d rdy=%b st=%b exp v=1 sum=10 rdy=0 st=1",
                         c, a_if.out_valid, a_if.out_sum, a_if.in_ready, dbg_a);
            end
            if (c == 3) a_if.out_ready = 1'b1;
            step();
        end
        checks++;
        if ({a_if.out_valid, a_if.in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL bp_release got v=%b rdy=%b exp v=0 rdy=1", a_if.out_valid, a_if.in_ready);
        end
        step();
        drive_a(1'b1, 8'd1, 1'b1);
        step();
        drive_a(1'b0, 8'd0, 1'b0);
        checks++;
        if ({a_if.out_valid, a_if.out_sum, a_if.out_count} !== {1'b1, 10'd10, 3'd2}) begin
            errors++;
            $display("FAIL bp_held_product got v=%b sum=%0d cnt=%0d exp v=1 sum=10 cnt=2",
                     a_if.out_valid, a_if.out_sum, a_if.out_count);
        end
        step();
    endtask

    task automatic test_overflow();
        logic [7:0] exp_sum;
`ifdef SATURATE_EN
        exp_sum = 8'd255;
`else
        exp_sum = 8'd44;
`endif
        b_if.out_ready = 1'b1;
        drive_b(1'b1, 8'd200, 1'b0);
        step();
        drive_b(1'b1, 8'd100, 1'b1);
        step();
        drive_b(1'b0, 8'd0, 1'b0);
        checks++;
        if ({b_if.out_valid, b_if.out_sum, b_if.out_count, b_if.out_ovf} !== {1'b1, exp_sum, 3'd2, 1'b1}) begin
            errors++;
            $display("FAIL ovf_frame got v=%b sum=%0d cnt=%0d ovf=%b exp v=1 sum=%0d cnt=2 ovf=1",
                     b_if.out_valid, b_if.out_sum, b_if.out_count, b_if.out_ovf, exp_sum);
        end
        step();
        drive_b(1'b1, 8'd3, 1'b1);
        step();
        drive_b(1'b0, 8'd0, 1'b0);
        checks++;
        if ({b_if.out_valid, b_if.out_sum, b_if.out_count, b_if.out_ovf} !== {1'b1, 8'd3, 3'd1, 1'b0}) begin
            errors++;
            $display("FAIL ovf_next_frame got v=%b sum=%0d cnt=%0d ovf=%b exp v=1 sum=3 cnt=1 ovf=0",
                     b_if.out_valid, b_if.out_sum, b_if.out_count, b_if.out_ovf);
        end
        step();
    endtask

    task automatic test_clear();
        drive_a(1'b1, 8'd6, 1'b0);
        step();
        step();
        clear_a = 1'b1;
        step();
        clear_a = 1'b0;
        drive_a(1'b0, 8'd0, 1'b0);
        checks++;
        if ({a_if.out_valid, a_if.in_ready, dbg_a, a_if.out_sum} !== {1'b0, 1'b1, ACCUM, 10'd10}) begin
            errors++;
            $display("FAIL clear_state got v=%b rdy=%b st=%b sum=%0d exp v=0 rdy=1 st=0 sum=10",
                     a_if.out_valid, a_if.in_ready, dbg_a, a_if.out_sum);
        end
        step();
        drive_a(1'b1, 8'd2, 1'b1);
        step();
        drive_a(1'b0, 8'd0, 1'b0);
        checks++;
        if ({a_if.out_valid, a_if.out_sum, a_if.out_count, a_if.out_ovf} !== {1'b1, 10'd2, 3'd1, 1'b0}) begin
            errors++;
            $display("FAIL clear_next_frame got v=%b sum=%0d cnt=%0d ovf=%b exp v=1 sum=2 cnt=1 ovf=0",
                     a_if.out_valid, a_if.out_sum, a_if.out_count, a_if.out_ovf);
        end
        step();
    endtask

    task automatic test_async_reset();
        drive_a(1'b1, 8'd3, 1'b0);
        step();
        step();
        drive_a(1'b0, 8'd0, 1'b0);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({a_if.out_valid, a_if.out_sum, a_if.out_count, a_if.out_ovf} !== 15'd0) begin
            errors++;
            $display("FAIL rst_midframe got %h exp %h",
                     {a_if.out_valid, a_if.out_sum, a_if.out_count, a_if.out_ovf}, 15'd0);
        end
        step();
        rst_n = 1'b1;
        step();
        a_if.out_ready = 1'b0;
        drive_a(1'b1, 8'd5, 1'b1);
        step();
        drive_a(1'b0, 8'd0, 1'b0);
        checks++;
        if ({a_if.out_valid, a_if.out_sum, a_if.out_count} !== {1'b1, 10'd5, 3'd1}) begin
            errors++;
            $display("FAIL rst_pre_hold got v=%b sum=%0d cnt=%0d exp v=1 sum=5 cnt=1",
                     a_if.out_valid, a_if.out_sum, a_if.out_count);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({a_if.out_valid, a_if.out_sum, a_if.out_count, a_if.out_ovf, dbg_a} !== {15'd0, ACCUM}) begin
            errors++;
            $display("FAIL rst_in_hold got %h exp %h",
                     {a_if.out_valid, a_if.out_sum, a_if.out_count, a_if.out_ovf, dbg_a}, {15'd0, ACCUM});
        end
        step();
        rst_n = 1'b1;
        a_if.out_ready = 1'b1;
        step();
        checks++;
        if ({a_if.out_valid, a_if.in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL rst_release got v=%b rdy=%b exp v=0 rdy=1", a_if.out_valid, a_if.in_ready);
        end
        for (int i = 0; i < 4; i++) begin
            drive_a(1'b1, 8'd4, 1'b0);
            step();
        end
        drive_a(1'b0, 8'd0, 1'b0);
        checks++;
        if ({a_if.out_valid, a_if.out_sum, a_if.out_count, a_if.out_ovf} !== {1'b1, 10'd16, 3'd4, 1'b0}) begin
            errors++;
            $display("FAIL rst_next_frame got v=%b sum=%0d cnt=%0d ovf=%b exp v=1 sum=16 cnt=4 ovf=0",
                     a_if.out_valid, a_if.out_sum, a_if.out_count, a_if.out_ovf);
        end
        step();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst_n          = 1'b0;
        clear_a        = 1'b0;
        clear_b        = 1'b0;
        a_if.out_ready = 1'b1;
        b_if.out_ready = 1'b1;
        drive_a(1'b0, 8'd0, 1'b0);
        drive_b(1'b0, 8'd0, 1'b0);

        test_reset();
        test_back_to_back();
        test_in_last();
        test_backpressure();
        test_overflow();
        test_clear();
        test_async_reset();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
